// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI memory subordinate: burst encodings,
// response codes, per-channel FSM state encodings and the common truth/zero
// macros used by the RTL.
`ifndef AXI_SHARED_DEFS
`define AXI_SHARED_DEFS
`define TRUE      1'b1
`define FALSE     1'b0
`define ZERO_WORD 32'h0000_0000
`endif

package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_e;

    // Map a sticky error flag onto the AXI response code.
    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sram_dp.sv
// Simple dual-port SRAM of 32-bit words: byte-enabled write port and a
// registered read port. A read and a write to the same word on the same edge
// return the old contents (read-first). Contents are never reset.
module axi_sram_dp #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            wstrb_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(1 << DEPTH_LOG2) - 1];
    logic [31:0] rdata_q;

    // Byte-lane write; only lanes with their strobe set are updated.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Registered read; output holds while re_i is low so a stalled beat stays stable.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 subordinate terminating single-outstanding read and write bursts into
// an on-chip SRAM. Read and write channels are independent FSMs sharing a
// dual-port RAM. Define AXI_SLV_RANGE_CHECK_EN to reject beats whose word
// index falls outside the RAM (dropped writes / zero reads with SLVERR);
// without it addresses alias modulo the depth.
//
// Handshake rule: a transfer happens on a rising clk edge where both valid and
// ready are high; ready/valid outputs here depend only on registered state.
`ifndef AXI_SHARED_DEFS
`define AXI_SHARED_DEFS
`define TRUE      1'b1
`define FALSE     1'b0
`define ZERO_WORD 32'h0000_0000
`endif

module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_awid,
    input  logic [31:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic [1:0]  axi_awburst,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic        axi_bid,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic        axi_arid,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic        axi_rid,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic        axi_rvalid,
    input  logic        axi_rready
);

`ifdef AXI_SLV_RANGE_CHECK_EN
    localparam int IDX_W = 30;          // full word index so out-of-range is visible
`else
    localparam int IDX_W = DEPTH_LOG2;  // index simply wraps modulo depth
`endif
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    w_state_e          w_state_q, w_state_d;
    logic              w_id_q, w_id_d;
    logic [IDX_W-1:0]  w_idx_q, w_idx_d;
    logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    burst_e            w_burst_q, w_burst_d;
    logic              w_err_q, w_err_d;

    r_state_e          r_state_q, r_state_d;
    logic              r_id_q, r_id_d;
    logic [IDX_W-1:0]  r_idx_q, r_idx_d;
    logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    burst_e            r_burst_q, r_burst_d;
    logic              r_oob_q, r_oob_d;

    // Low while in reset and on the edge that applies it; gates every output to 0.
    logic              out_en_q;

    logic              ram_we, ram_re;
    logic [31:0]       ram_rdata;
    logic [31:0]       aw_off, ar_off;
    logic              w_in_range, r_in_range;
    logic              unused_bits;

    assign aw_off = axi_awaddr - BASE_ADDR;
    assign ar_off = axi_araddr - BASE_ADDR;
    assign unused_bits = ^{axi_awsize, axi_arsize, aw_off, ar_off};

`ifdef AXI_SLV_RANGE_CHECK_EN
    assign w_in_range = (w_idx_q >> DEPTH_LOG2) == '0;
    assign r_in_range = (r_idx_q >> DEPTH_LOG2) == '0;
`else
    assign w_in_range = `TRUE;
    assign r_in_range = `TRUE;
`endif

    axi_sram_dp #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (w_idx_q[DEPTH_LOG2-1:0]),
        .wdata_i (axi_wdata),
        .wstrb_i (axi_wstrb),
        .re_i    (ram_re),
        .raddr_i (r_idx_q[DEPTH_LOG2-1:0]),
        .rdata_o (ram_rdata)
    );

    // State and burst-context registers for both channels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= `FALSE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= BURST_INCR;
            w_err_q   <= `FALSE;
            r_state_q <= R_IDLE;
            r_id_q    <= `FALSE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= BURST_INCR;
            r_oob_q   <= `FALSE;
            out_en_q  <= `FALSE;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
            r_oob_q   <= r_oob_d;
            out_en_q  <= `TRUE;
        end
    end

    // Write channel next state: latch AW, write each W beat, collect errors.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        ram_we    = `FALSE;
        case (w_state_q)
            W_IDLE: begin
                if (axi_awvalid && axi_awready) begin
                    w_id_d    = axi_awid;
                    w_idx_d   = aw_off[IDX_W+1:2];
                    w_len_d   = axi_awlen;
                    w_burst_d = burst_e'(axi_awburst);
                    w_cnt_d   = '0;
                    w_err_d   = `FALSE;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_wvalid && axi_wready) begin
                    // No RAM write on an edge where reset is being applied.
                    ram_we  = w_in_range && rst;
                    if ((axi_wlast != (w_cnt_q == w_len_q)) || !w_in_range) begin
                        w_err_d = `TRUE;
                    end
                    if (w_burst_q != BURST_FIXED) begin
                        w_idx_d = w_idx_q + IDX_ONE;
                    end
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi_bready && axi_bvalid) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel next state: latch AR, fetch one word, present it, repeat.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        r_oob_d   = r_oob_q;
        ram_re    = `FALSE;
        case (r_state_q)
            R_IDLE: begin
                if (axi_arvalid && axi_arready) begin
                    r_id_d    = axi_arid;
                    r_idx_d   = ar_off[IDX_W+1:2];
                    r_len_d   = axi_arlen;
                    r_burst_d = burst_e'(axi_arburst);
                    r_cnt_d   = '0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_re    = `TRUE;
                r_oob_d   = !r_in_range;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (axi_rvalid && axi_rready) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        if (r_burst_q != BURST_FIXED) begin
                            r_idx_d = r_idx_q + IDX_ONE;
                        end
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Channel outputs decoded from state; all forced to 0 while in reset.
    always_comb begin
        axi_awready = out_en_q && (w_state_q == W_IDLE);
        axi_wready  = out_en_q && (w_state_q == W_DATA);
        axi_bvalid  = out_en_q && (w_state_q == W_RESP);
        axi_bresp   = axi_bvalid ? resp_of(w_err_q) : RESP_OKAY;
        axi_bid     = axi_bvalid && w_id_q;
        axi_arready = out_en_q && (r_state_q == R_IDLE);
        axi_rvalid  = out_en_q && (r_state_q == R_DATA);
        axi_rdata   = (axi_rvalid && !r_oob_q) ? ram_rdata : `ZERO_WORD;
        axi_rresp   = axi_rvalid ? resp_of(r_oob_q) : RESP_OKAY;
        axi_rlast   = axi_rvalid && (r_cnt_q == r_len_q);
        axi_rid     = axi_rvalid && r_id_q;
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: single and burst writes/reads, byte
// strobes, FIXED/WRAP bursts, wlast error, out-of-range (or aliasing) reads
// and reset in the middle of a read burst.
module tb_axi_mem_slave;

  localparam int BUDGET = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        axi_awid = 1'b0;
  logic [31:0] axi_awaddr = '0;
  logic [7:0]  axi_awlen = '0;
  logic [2:0]  axi_awsize = 3'd2;
  logic [1:0]  axi_awburst = 2'b01;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wlast = 1'b0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic        axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;
  logic        axi_arid = 1'b0;
  logic [31:0] axi_araddr = '0;
  logic [7:0]  axi_arlen = '0;
  logic [2:0]  axi_arsize = 3'd2;
  logic [1:0]  axi_arburst = 2'b01;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic        axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wd [16];

  axi_mem_slave #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one write burst, wlast on beat bad_last if >= 0, else on the true last beat
  task automatic axi_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] strb, input int bad_last,
                           input logic [1:0] exp_resp, input string tag);
    int n;
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst; axi_awvalid = 1'b1;
    n = 0;
    while (!axi_awready && n < BUDGET) begin tick(); n++; end
    if (!axi_awready) check({tag, "_aw_timeout"}, 32'd0, 32'd1);
    tick();
    axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      axi_wdata = wd[b];
      axi_wstrb = strb;
      axi_wlast = (bad_last >= 0) ? (b == bad_last) : (b == int'(len));
      axi_wvalid = 1'b1;
      n = 0;
      while (!axi_wready && n < BUDGET) begin tick(); n++; end
      if (!axi_wready) check({tag, "_w_timeout"}, 32'd0, 32'd1);
      tick();
      axi_wvalid = 1'b0;
      axi_wlast = 1'b0;
    end
    check({tag, "_bvalid_lat"}, {31'd0, axi_bvalid}, 32'd1);
    n = 0;
    while (!axi_bvalid && n < BUDGET) begin tick(); n++; end
    check({tag, "_bresp"}, {30'd0, axi_bresp}, {30'd0, exp_resp});
    check({tag, "_bid"}, {31'd0, axi_bid}, {31'd0, id});
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    check({tag, "_bdone"}, {31'd0, axi_bvalid}, 32'd0);
  endtask

  // driver + scoreboard: one read burst, expected beats taken from exp_q
  task automatic axi_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_beat,
                          input logic [1:0] exp_resp, input string tag);
    int n;
    logic [31:0] exp;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst; axi_arvalid = 1'b1;
    n = 0;
    while (!axi_arready && n < BUDGET) begin tick(); n++; end
    if (!axi_arready) check({tag, "_ar_timeout"}, 32'd0, 32'd1);
    tick();
    axi_arvalid = 1'b0;
    check({tag, "_rvalid_n1"}, {31'd0, axi_rvalid}, 32'd0);
    tick();
    check({tag, "_rvalid_n2"}, {31'd0, axi_rvalid}, 32'd1);
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!axi_rvalid && n < BUDGET) begin tick(); n++; end
      if (!axi_rvalid) check({tag, "_r_timeout"}, 32'd0, 32'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      if (b == stall_beat) begin
        for (int s = 0; s < 3; s++) begin
          tick();
          check({tag, "_stall_valid"}, {31'd0, axi_rvalid}, 32'd1);
          check({tag, "_stall_data"}, axi_rdata, exp);
        end
      end
      check({tag, "_rdata"}, axi_rdata, exp);
      check({tag, "_rlast"}, {31'd0, axi_rlast}, {31'd0, (b == int'(len))});
      check({tag, "_rresp"}, {30'd0, axi_rresp}, {30'd0, exp_resp});
      check({tag, "_rid"}, {31'd0, axi_rid}, {31'd0, id});
      axi_rready = 1'b1;
      tick();
      axi_rready = 1'b0;
    end
    check({tag, "_rdone"}, {31'd0, axi_rvalid}, 32'd0);
  endtask

  initial begin
    int n;
    // reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst_awready", {31'd0, axi_awready}, 32'd0);
    check("rst_arready", {31'd0, axi_arready}, 32'd0);
    check("rst_wready", {31'd0, axi_wready}, 32'd0);
    check("rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    check("rst_rdata", axi_rdata, 32'd0);
    rst = 1'b1;
    tick();
    check("rel_awready", {31'd0, axi_awready}, 32'd1);
    check("rel_arready", {31'd0, axi_arready}, 32'd1);

    // single write / read
    wd[0] = 32'hDEAD_BEEF;
    axi_write(1'b1, 32'h10, 8'd0, 2'b01, 4'hF, -1, 2'b00, "w_single");
    exp_q.push_back(32'hDEAD_BEEF);
    axi_read(1'b1, 32'h10, 8'd0, 2'b01, -1, 2'b00, "r_single");

    // INCR burst, single-beat readback, then a burst read with a stall on beat 2
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    axi_write(1'b0, 32'h100, 8'd3, 2'b01, 4'hF, -1, 2'b00, "w_incr");
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'(i + 1));
      axi_read(1'b0, 32'h100 + 32'(4 * i), 8'd0, 2'b01, -1, 2'b00, "r_incr_single");
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    axi_read(1'b1, 32'h100, 8'd3, 2'b01, 1, 2'b00, "r_incr_burst");

    // byte strobes
    wd[0] = 32'hFFFF_FFFF;
    axi_write(1'b0, 32'h40, 8'd0, 2'b01, 4'hF, -1, 2'b00, "w_full");
    wd[0] = 32'h0000_0012;
    axi_write(1'b0, 32'h40, 8'd0, 2'b01, 4'b0001, -1, 2'b00, "w_strb");
    exp_q.push_back(32'hFFFF_FF12);
    axi_read(1'b0, 32'h40, 8'd0, 2'b01, -1, 2'b00, "r_strb");

    // FIXED burst: both beats land on 0x20, neighbour 0x24 untouched
    wd[0] = 32'h0000_0055;
    axi_write(1'b0, 32'h24, 8'd0, 2'b01, 4'hF, -1, 2'b00, "w_nbr");
    wd[0] = 32'h0000_000A; wd[1] = 32'h0000_000B;
    axi_write(1'b1, 32'h20, 8'd1, 2'b00, 4'hF, -1, 2'b00, "w_fixed");
    exp_q.push_back(32'h0000_000B);
    exp_q.push_back(32'h0000_0055);
    axi_read(1'b0, 32'h20, 8'd1, 2'b01, -1, 2'b00, "r_fixed");

    // WRAP treated as INCR
    wd[0] = 32'h0000_0007; wd[1] = 32'h0000_0008;
    axi_write(1'b0, 32'h300, 8'd1, 2'b10, 4'hF, -1, 2'b00, "w_wrap");
    exp_q.push_back(32'h0000_0008);
    axi_read(1'b0, 32'h304, 8'd0, 2'b01, -1, 2'b00, "r_wrap");

    // early wlast -> SLVERR, data still written; next clean burst is OKAY again
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
    axi_write(1'b1, 32'h200, 8'd2, 2'b01, 4'hF, 1, 2'b10, "w_badlast");
    exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33);
    axi_read(1'b1, 32'h200, 8'd2, 2'b01, -1, 2'b00, "r_badlast");
    wd[0] = 32'h44;
    axi_write(1'b0, 32'h20C, 8'd0, 2'b01, 4'hF, -1, 2'b00, "w_clean");

    // 0x1000 is one past the end of a 1024-word RAM
    wd[0] = 32'h0BAD_F00D;
    axi_write(1'b0, 32'h0, 8'd0, 2'b01, 4'hF, -1, 2'b00, "w_word0");
`ifdef AXI_SLV_RANGE_CHECK_EN
    exp_q.push_back(32'h0);
    axi_read(1'b0, 32'h1000, 8'd0, 2'b01, -1, 2'b10, "r_oob");
`else
    exp_q.push_back(32'h0BAD_F00D);
    axi_read(1'b0, 32'h1000, 8'd0, 2'b01, -1, 2'b00, "r_alias");
`endif

    // reset while a read beat is being presented
    axi_arid = 1'b0; axi_araddr = 32'h100; axi_arlen = 8'd3; axi_arburst = 2'b01; axi_arvalid = 1'b1;
    n = 0;
    while (!axi_arready && n < BUDGET) begin tick(); n++; end
    tick();
    axi_arvalid = 1'b0;
    n = 0;
    while (!axi_rvalid && n < BUDGET) begin tick(); n++; end
    check("mid_rvalid", {31'd0, axi_rvalid}, 32'd1);
    rst = 1'b0;
    tick();
    check("mid_rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    check("mid_rst_arready", {31'd0, axi_arready}, 32'd0);
    check("mid_rst_rdata", axi_rdata, 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_arready", {31'd0, axi_arready}, 32'd1);
    check("post_rst_awready", {31'd0, axi_awready}, 32'd1);
    check("post_rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    axi_read(1'b1, 32'h10, 8'd0, 2'b01, -1, 2'b00, "r_after_rst");

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
AXI4 subordinate (responder) that terminates single-outstanding AXI read/write transactions into an on-chip word-addressed SRAM. It is the target side for the team's AXI initiator bridge. It lets pipeline stages, switch tables and the test bench share memory over AXI without an external memory controller. Read and write channels run as independent FSMs over a dual-port RAM.

Parameters:
DEPTH_LOG2, 10, log2 of the number of 32-bit words in the SRAM
BASE_ADDR, 32'h0000_0000, byte address that maps to word 0

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
axi_awid  in  1  write ID
axi_awaddr  in  32  write byte address
axi_awlen  in  8  beats-1
axi_awsize  in  3  ignored; every beat is 32 bits
axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
axi_awvalid  in  1  AW valid
axi_awready  out  1  AW ready
axi_wdata  in  32  write data
axi_wstrb  in  4  byte enables
axi_wlast  in  1  last write beat
axi_wvalid  in  1  W valid
axi_wready  out  1  W ready
axi_bid  out  1  echoed awid
axi_bresp  out  2  00 OKAY, 10 SLVERR
axi_bvalid  out  1  B valid
axi_bready  in  1  B ready
axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid  in  1/32/8/3/2/1  read address channel, same semantics as AW
axi_arready  out  1  AR ready
axi_rid  out  1  echoed arid
axi_rdata  out  32  read data
axi_rresp  out  2  OKAY/SLVERR
axi_rlast  out  1  last read beat
axi_rvalid  out  1  R valid
axi_rready  in  1  R ready
AWLOCK/CACHE/PROT/QOS and AR equivalents are not ported. Initiators tie them off.

Behaviour:
- Reset: rst=0 sampled on a clk edge forces both FSMs to IDLE. All outputs go to 0, including awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast and rid. SRAM contents are preserved. A reset mid-burst abandons the burst with no B or R response.
- Write FSM:
  - W_IDLE: awready=1. On awvalid&awready, latch id, word index ((awaddr-BASE_ADDR)>>2), len and burst. Go to W_DATA with awready=0 and wready=1.
  - W_DATA: each wvalid&wready writes wdata under wstrb. The index increments by 1 for INCR/WRAP and holds for FIXED. The beat counter counts up to len.
  - On the beat where count==len: go to W_RESP, wready=0, bvalid=1, bid=latched id. If wlast disagrees with the count on any beat, bresp=SLVERR; the data is still written.
  - W_RESP: hold bvalid/bresp/bid until bready, then return to W_IDLE with awready=1 on the next cycle.
  - W is never accepted before AW. Initiators that present AW and W together see wready one cycle after the AW handshake.
- Read FSM:
  - R_IDLE: arready=1. On handshake, latch the fields and go to R_FETCH with arready=0.
  - R_FETCH: present the index to the RAM read port (1-cycle registered read). Go to R_DATA.
  - R_DATA: rvalid=1, rdata=RAM output, rlast=(count==arlen), rid=latched id. These hold until rready.
  - On the handshake: if not last, advance the index per burst type and return to R_FETCH; else return to R_IDLE.
  - Latency: AR handshake at edge N gives rvalid at edge N+2. Beat throughput is 1 per 2 cycles.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data (read-first).
- Index arithmetic is DEPTH_LOG2 bits wide and wraps modulo depth.
- Address bits [1:0] are ignored.

Optional Feature:
Macro AXI_SLV_RANGE_CHECK_EN.
- Defined: each beat's index is checked as (addr-BASE_ADDR)>>2 < 2**DEPTH_LOG2, with bits above DEPTH_LOG2 zero. A write beat that fails the check is dropped and the burst's bresp becomes SLVERR. A read beat that fails returns rdata=0 with rresp=SLVERR.
- Undefined: no check is made. Addresses alias modulo depth and every response is OKAY, except for a wlast mismatch.

Decomposition:
- Package axi_pkg:
  - burst type enum (FIXED/INCR/WRAP)
  - response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10)
  - write-state enum (W_IDLE/W_DATA/W_RESP) and read-state enum (R_IDLE/R_FETCH/R_DATA)
- Uses the shared `TRUE/`FALSE/`ZERO_WORD definitions.
- One sub-module, axi_sram_dp: simple dual-port RAM with a byte-enabled write port, a 1-cycle registered read port and read-first behaviour.

Test Plan:
- Single write: AW addr 0x10 with len 0, W 0xDEADBEEF, strb 1111, wlast 1 -> bvalid 1 cycle after the W beat, bresp 00, bid = awid. Then AR 0x10 -> rvalid 2 cycles after AR, rdata 0xDEADBEEF, rlast 1.
- INCR burst: len 3 at 0x100, data 1..4 -> reading 0x100/0x104/0x108/0x10C returns 1, 2, 3, 4. A len-3 read returns four beats with rlast only on the 4th. rready held low 3 cycles on beat 2 -> data stable.
- Byte strobes: word 0xFFFFFFFF, then write 0x00000012 with strb 0001 -> read returns 0xFFFFFF12.
- FIXED burst: len 1 at 0x20, data 0xA then 0xB -> reading 0x20 returns 0xB.
- Errors and reset:
  - wlast asserted on beat 1 of a len-2 burst -> bresp 10.
  - With AXI_SLV_RANGE_CHECK_EN and DEPTH_LOG2=10, read 0x1000 -> rresp 10, rdata 0.
  - rst=0 during R_DATA -> next cycle rvalid 0, arready 0. First cycle after release -> arready 1. Previously written data intact.
